// File: rtl/sid_spi_slave.sv
// SPI mode-0 receive-only slave: 16-bit frames {W, 2'bxx, addr[4:0], data[7:0]} become SID register strobes.
// Optional SPI_ADDR_AUTOINC_EN: after the first frame under one ss, each further byte targets addr+1.
module sid_spi_slave (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ss,
  input  logic       sclk,
  input  logic       mosi,
  output logic [4:0] addr,
  output logic [7:0] data,
  output logic       write_en,
  output logic       data_rdy
);

  localparam int unsigned FRAME_W = 16;
  localparam int unsigned CNT_W   = 4;
  localparam int unsigned ADDR_W  = 5;
  localparam int unsigned DATA_W  = 8;

  // Two-flop synchronizers plus a delayed copy of ss/sclk for edge detection
  logic ss_meta, ss_s, ss_d;
  logic sclk_meta, sclk_s, sclk_d;
  logic mosi_meta, mosi_s;

  logic [FRAME_W-1:0] shift_q;
  logic [CNT_W-1:0]   bit_cnt;
  logic               armed;

  logic               sclk_rise_c;
  logic               ss_fall_c;
  logic               ss_rise_c;
  logic               shift_en_c;
  logic               frame_done_c;
  logic               byte_done_c;
  logic [FRAME_W-1:0] shift_nxt_c;

`ifdef SPI_ADDR_AUTOINC_EN
  logic burst_q;
  logic w_q;
`endif

  // ss synchronizer resets low so an ss already held low through reset is not seen as a new frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ss_meta   <= 1'b0;
      ss_s      <= 1'b0;
      ss_d      <= 1'b0;
      sclk_meta <= 1'b0;
      sclk_s    <= 1'b0;
      sclk_d    <= 1'b0;
      mosi_meta <= 1'b0;
      mosi_s    <= 1'b0;
    end else begin
      ss_meta   <= ss;
      ss_s      <= ss_meta;
      ss_d      <= ss_s;
      sclk_meta <= sclk;
      sclk_s    <= sclk_meta;
      sclk_d    <= sclk_s;
      mosi_meta <= mosi;
      mosi_s    <= mosi_meta;
    end
  end

  // Gating on the delayed ss lets a final bit coinciding with ss deassertion still land
  always_comb begin
    sclk_rise_c = sclk_s & ~sclk_d;
    ss_fall_c   = ~ss_s & ss_d;
    ss_rise_c   = ss_s & ~ss_d;
    shift_en_c  = armed & ~ss_d & sclk_rise_c;
    shift_nxt_c = {shift_q[FRAME_W-2:0], mosi_s};
`ifdef SPI_ADDR_AUTOINC_EN
    frame_done_c = shift_en_c & ~burst_q & (bit_cnt == CNT_W'(FRAME_W - 1));
    byte_done_c  = shift_en_c & burst_q & (bit_cnt == CNT_W'(DATA_W - 1));
`else
    frame_done_c = shift_en_c & (bit_cnt == CNT_W'(FRAME_W - 1));
    byte_done_c  = 1'b0;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q  <= '0;
      bit_cnt  <= '0;
      armed    <= 1'b0;
      addr     <= '0;
      data     <= '0;
      write_en <= 1'b0;
      data_rdy <= 1'b0;
`ifdef SPI_ADDR_AUTOINC_EN
      burst_q  <= 1'b0;
      w_q      <= 1'b0;
`endif
    end else begin
      write_en <= 1'b0;
      data_rdy <= 1'b0;
      if (ss_fall_c) begin
        shift_q <= '0;
        bit_cnt <= '0;
        armed   <= 1'b1;
`ifdef SPI_ADDR_AUTOINC_EN
        burst_q <= 1'b0;
`endif
      end else begin
        if (shift_en_c) begin
          shift_q <= shift_nxt_c;
          bit_cnt <= bit_cnt + CNT_W'(1);
          if (frame_done_c) begin
            addr     <= shift_nxt_c[12:8];
            data     <= shift_nxt_c[DATA_W-1:0];
            data_rdy <= 1'b1;
            write_en <= shift_nxt_c[FRAME_W-1];
`ifdef SPI_ADDR_AUTOINC_EN
            burst_q  <= 1'b1;
            w_q      <= shift_nxt_c[FRAME_W-1];
            bit_cnt  <= '0;
`endif
          end else if (byte_done_c) begin
`ifdef SPI_ADDR_AUTOINC_EN
            addr     <= addr + ADDR_W'(1);
            data     <= shift_nxt_c[DATA_W-1:0];
            data_rdy <= 1'b1;
            write_en <= w_q;
            bit_cnt  <= '0;
`endif
          end
        end
        if (ss_rise_c) begin
          armed <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_sid_spi_slave.sv
// Directed + randomized SPI frames checked against a frame-level model of the SID register writes.
module tb_sid_spi_slave;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ss = 1'b1;
  logic       sclk = 1'b0;
  logic       mosi = 1'b0;
  logic [4:0] addr;
  logic [7:0] data;
  logic       write_en;
  logic       data_rdy;

  int errors = 0;
  int checks = 0;

  logic [13:0] exp_q[$];
  logic [13:0] obs_q[$];
  logic [4:0]  m_addr = '0;
  logic [7:0]  m_data = '0;
  int          we_orphan = 0;
  int          wide_pulse = 0;
  logic        rdy_prev = 1'b0;

  sid_spi_slave dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ss       (ss),
    .sclk     (sclk),
    .mosi     (mosi),
    .addr     (addr),
    .data     (data),
    .write_en (write_en),
    .data_rdy (data_rdy)
  );

  always #5 clk = ~clk;

  // Record every strobe as {write_en, addr, data}; flag malformed pulses
  always @(negedge clk) begin
    if (data_rdy) obs_q.push_back({write_en, addr, data});
    if (write_en && !data_rdy) we_orphan++;
    if (data_rdy && rdy_prev) wide_pulse++;
    rdy_prev = data_rdy;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected register writes for n bits (MSB first) sent under one ss assertion
  function automatic void model(input logic [63:0] bits, input int n);
    int pos = 0;
    logic [15:0] fr;
`ifdef SPI_ADDR_AUTOINC_EN
    logic w;
    if (n >= 16) begin
      fr = 16'(bits >> (n - 16));
      w = fr[15];
      m_addr = fr[12:8];
      m_data = fr[7:0];
      exp_q.push_back({w, m_addr, m_data});
      pos = 16;
      while (pos + 8 <= n) begin
        m_addr = 5'((int'(m_addr) + 1) % 32);
        m_data = 8'(bits >> (n - pos - 8));
        exp_q.push_back({w, m_addr, m_data});
        pos += 8;
      end
    end
`else
    while (pos + 16 <= n) begin
      fr = 16'(bits >> (n - pos - 16));
      m_addr = fr[12:8];
      m_data = fr[7:0];
      exp_q.push_back({fr[15], m_addr, m_data});
      pos += 16;
    end
`endif
  endfunction

  // Drive n bits; quick raises ss together with the last sclk rising edge
  task automatic send(input logic [63:0] bits, input int n, input bit quick, input bit keep_ss);
    ss = 1'b0;
    #40;
    for (int i = n - 1; i >= 0; i--) begin
      mosi = bits[i];
      sclk = 1'b0;
      #40;
      sclk = 1'b1;
      if (quick && i == 0) ss = 1'b1;
      #40;
    end
    sclk = 1'b0;
    #40;
    if (!keep_ss) ss = 1'b1;
    #100;
  endtask

  task automatic compare(input string tag);
    chk({tag, "_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      chk($sformatf("%s_ev%0d", tag, i), 32'(obs_q[i]), 32'(exp_q[i]));
    chk({tag, "_addr"}, 32'(addr), 32'(m_addr));
    chk({tag, "_data"}, 32'(data), 32'(m_data));
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic txn(input string tag, input logic [63:0] bits, input int n, input bit quick);
    obs_q.delete();
    model(bits, n);
    send(bits, n, quick, 1'b0);
    compare(tag);
  endtask

  initial begin
    logic [63:0] rb;
    int rn;
    #33;
    chk("reset_addr", 32'(addr), 32'h0);
    chk("reset_data", 32'(data), 32'h0);
    chk("reset_rdy", 32'(data_rdy), 32'h0);
    rst_n = 1'b1;
    #50;

    txn("read", 64'h0C33, 16, 1'b0);
    chk("read_addr_abs", 32'(addr), 32'h0C);

    // Reset in the middle of a frame, then finish the bits without a new ss edge
    obs_q.delete();
    send(64'h8A, 7, 1'b0, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    #20;
    chk("midrst_addr", 32'(addr), 32'h0);
    chk("midrst_data", 32'(data), 32'h0);
    chk("midrst_we", 32'(write_en), 32'h0);
    chk("midrst_rdy", 32'(data_rdy), 32'h0);
    rst_n = 1'b1;
    m_addr = '0;
    m_data = '0;
    obs_q.delete();
    send(64'h155, 9, 1'b0, 1'b0);
    compare("no_fresh_ss");

    txn("write", 64'h8A55, 16, 1'b0);
    chk("write_abs", 32'({addr, data}), 32'h0A55);
    txn("abort", 64'h13E, 9, 1'b0);
    txn("b2b", 64'h8101_9FFE, 32, 1'b0);
    txn("autoinc", 64'h9E11_2233, 32, 1'b0);
    txn("wrap8", 64'h9F00_44, 24, 1'b0);
    txn("simul_ss", 64'h8777, 16, 1'b1);

    // sclk activity and mosi noise with ss high must be ignored
    obs_q.delete();
    for (int i = 0; i < 40; i++) begin
      mosi = 1'($urandom);
      sclk = ~sclk;
      #30;
    end
    sclk = 1'b0;
    #100;
    compare("noise");

    for (int k = 0; k < 16; k++) begin
      rb = {$urandom, $urandom};
      rn = $urandom_range(1, 48);
      txn($sformatf("rand%0d", k), rb, rn, 1'(k % 5 == 4));
    end

    chk("we_without_rdy", 32'(we_orphan), 32'h0);
    chk("pulse_width", 32'(wide_pulse), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sid_spi_slave.md
# sid_spi_slave

SPI receive-only slave that turns serial register-write frames from the host MCU into parallel SID register accesses. It sits between the external SPI pins and the SID register file: each completed frame presents a 5-bit register address and an 8-bit data value with a one-cycle strobe. All SPI inputs are asynchronous to the system clock and are synchronized internally.

## Interface
- No parameters.
- clk  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- ss  in  1  SPI slave select, active low, asynchronous.
- sclk  in  1  SPI serial clock, asynchronous; mode 0 (idle low, sample on rising edge).
- mosi  in  1  SPI data in, MSB first.
- addr  out  5  register address of the last completed frame.
- data  out  8  data byte of the last completed frame.
- write_en  out  1  one-clk pulse: completed frame is a write (W bit = 1).
- data_rdy  out  1  one-clk pulse: any frame completed (read or write).

## Operation
- Input conditioning: ss, sclk, mosi each pass through a 2-flop synchronizer; a third registered copy of sclk and ss gives edge detection in the clk domain.
- Frame format: 16 bits, MSB first: bit15 = W (1 = write, 0 = read/no-op), bits14:13 reserved and ignored, bits12:8 = addr, bits7:0 = data.
- While synchronized ss is low, each detected sclk rising edge shifts the synchronized mosi into a 16-bit shift register and increments a 4-bit bit counter.
- On the 16th bit: addr and data load from the shift register; data_rdy pulses; write_en pulses in the same cycle only if W = 1. Bit counter wraps to 0, so further bits under the same ss form a new frame.
- Falling edge of synchronized ss: bit counter and shift register clear. Rising edge of ss before 16 bits: partial frame discarded, no strobes, addr/data unchanged.
- sclk edges while ss is high are ignored.
- addr and data hold their values until the next completed frame.

## Timing
- Reset values: addr = 0, data = 0, write_en = 0, data_rdy = 0, bit counter = 0, shift register = 0. Reset mid-frame discards the frame; a new frame requires a fresh ss falling edge.
- Latency: data_rdy/write_en assert 3 clk cycles after the 16th sclk rising edge is first captured by the synchronizer (±1 cycle from async sampling); pulse width exactly 1 clk.
- sclk high and low phases must each exceed 1 clk period (e.g. clk 100 MHz, sclk up to 40 MHz); mosi must be stable for ≥2 clk periods around the sclk rising edge.
- ss setup before first sclk rising edge and hold after last: ≥3 clk periods.
- Simultaneous 16th bit and ss rising edge in the same clk cycle: frame completes (bit shift takes priority over ss deassertion).

## Configuration
- SPI_ADDR_AUTOINC_EN defined: after the first 16-bit frame under one ss assertion, every further 8 bits is a data byte for addr+1 (5-bit wrap, 31 → 0), with the W bit of the first frame reused; each byte pulses data_rdy (and write_en if W = 1).
- Not defined: every 16 bits under one ss is an independent full frame, as described above.

## Test plan
- Reset: assert rst_n = 0 mid-frame → all outputs 0; after release, frame 0x8A55 → addr = 0x0A, data = 0x55, write_en and data_rdy pulse once for 1 clk.
- Read frame 0x0C33 → addr = 0x0C, data = 0x33, data_rdy pulses, write_en stays 0.
- Abort: ss low, 9 bits of 0x9F00, ss high → no strobes, addr/data unchanged.
- Back-to-back (macro off): frames 0x8101 then 0x9FFE under one ss → two write_en pulses; final addr = 0x1F, data = 0xFE.
- Auto-increment (macro on): 0x9E11 then bytes 0x22, 0x33 under one ss → writes (0x1E,0x11), (0x1F,0x22), (0x00,0x33).
- sclk toggling with ss high plus mosi noise → no strobes, outputs unchanged.
